// File: rtl/ssi_pkg.sv
// Shared constants for the seven-segment indicator: digit count, blank code
// and the hex-to-segment pattern table (active high, gfedcba).
package ssi_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry n holds the pattern for hex digit n; entry 15 is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/ssi_hex_to_seg.sv
// Combinational hex digit to seven-segment decoder (active-high, gfedcba).
module hex_to_seg
  import ssi_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/ssi_top.sv
// Seven-segment indicator top: enter-button capture, 8-digit shift buffer,
// scan prescaler and registered anode/cathode drive.
module ssi_top #(
  parameter int SCAN_DIV_BITS = 17,
  parameter int NUM_DIGITS    = 8
) (
  input  logic       clk100mhz,
  input  logic       reset,
  input  logic       enter,
  input  logic [3:0] switches,
  output logic [7:0] anodes,
  output logic [7:0] cathodes
);

  import ssi_pkg::*;

  logic       enter_s1;
  logic       enter_s2;
  logic       enter_d;
  logic [1:0] live;
  logic       armed;
  logic       push;

  logic [3:0]            digit_buf [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] valid;

  logic [SCAN_DIV_BITS-1:0] prescale;
  logic [2:0]               idx;

  logic [3:0] cur_digit;
  logic       cur_valid;
  logic [6:0] cur_seg;

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge values of its neighbours, whatever the statement order.
  // live[1] marks that enter_s2 holds a genuine sample taken after reset, so a
  // button already held high at release only arms once it has been seen low.
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      enter_s1 <= 1'b0;
      enter_s2 <= 1'b0;
      enter_d  <= 1'b0;
      live     <= 2'b00;
      armed    <= 1'b0;
      push     <= 1'b0;
    end else begin
      enter_s1 <= enter;
      enter_s2 <= enter_s1;
      enter_d  <= enter_s2;
      live     <= {live[0], 1'b1};
      armed    <= armed | (live[1] & ~enter_s2);
      push     <= enter_s2 & ~enter_d & armed;
    end
  end

  // NOTE: the digit buffer is a small register array, not a RAM, so it is
  // cleared on reset along with the rest of the state.
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= 4'h0;
      valid <= '0;
    end else if (push) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) digit_buf[i] <= digit_buf[i-1];
      digit_buf[0] <= switches;
      valid        <= {valid[NUM_DIGITS-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      prescale <= '0;
      idx      <= 3'd0;
    end else begin
      prescale <= prescale + SCAN_DIV_BITS'(1);
      if (&prescale) idx <= idx + 3'd1;
    end
  end

  assign cur_digit = digit_buf[idx];
  assign cur_valid = valid[idx];

  hex_to_seg u_hex_to_seg (
    .digit (cur_digit),
    .seg   (cur_seg)
  );

  // Decimal point (bit 7) stays off; unwritten digits are blanked.
  always_ff @(posedge clk100mhz or negedge reset) begin
    if (!reset) begin
      anodes   <= 8'hFF;
      cathodes <= SEG_BLANK;
    end else begin
      anodes   <= ~(8'b1 << idx);
      cathodes <= cur_valid ? {1'b1, ~cur_seg} : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_ssi_top.sv
// Self-checking bench for ssi_top: a cycle-level display model plus directed
// pushes with hand-computed cathode codes.
module tb_ssi_top;

  localparam int SCAN = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       enter;
  logic [3:0] switches;
  logic [7:0] anodes;
  logic [7:0] cathodes;

  int n_checks = 0;
  int n_fail   = 0;

  ssi_top #(.SCAN_DIV_BITS(SCAN), .NUM_DIGITS(8)) dut (
    .clk100mhz (clk),
    .reset     (reset),
    .enter     (enter),
    .switches  (switches),
    .anodes    (anodes),
    .cathodes  (cathodes)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Display model: k counts clock edges since reset release; the digit list
  // holds the most recent pushes, newest at position 0.
  int         k;
  bit         armed;
  logic       prev;
  int         count;
  logic [3:0] mbuf [8];
  int         pend [$];
  logic [7:0] exp_an;
  logic [7:0] exp_ca;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      k = 0; armed = 0; prev = 0; count = 0;
      pend.delete();
      exp_an = 8'hFF; exp_ca = 8'hFF;
    end else begin
      int d;
      k++;
      d = ((k - 1) >> SCAN) % 8;
      exp_an = ~(8'b1 << d);
      exp_ca = (d < count) ? {1'b1, ~seg_of(mbuf[d])} : 8'hFF;
      while (pend.size() > 0 && pend[0] == k) begin
        void'(pend.pop_front());
        for (int i = 7; i > 0; i--) mbuf[i] = mbuf[i-1];
        mbuf[0] = switches;
        if (count < 8) count++;
      end
      if (!armed) armed = (enter == 1'b0);
      else if (enter && !prev) pend.push_back(k + 3);
      prev = enter;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("reset_anodes", anodes, 8'hFF);
      check("reset_cathodes", cathodes, 8'hFF);
    end else begin
      check("model_anodes", anodes, exp_an);
      check("model_cathodes", cathodes, exp_ca);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_digit(input logic [7:0] an, input logic [7:0] ca, input string name);
    int n = 0;
    while (anodes !== an && n < 64) begin
      @(negedge clk);
      n++;
    end
    #1;
    check({name, "_anode"}, anodes, an);
    check({name, "_cathode"}, cathodes, ca);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enter = 1'b0; switches = 4'h0;
    repeat (3) begin
      tick(2);
      enter = ~enter;
    end
    #1;
    check("hold_anodes", anodes, 8'hFF);
    check("hold_cathodes", cathodes, 8'hFF);

    // Release with the button held: no push may be recorded.
    enter = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(40);
    wait_digit(8'h7F, 8'hFF, "blank_d7");
    wait_digit(8'hFE, 8'hFF, "blank_d0");
    enter = 1'b0;
    tick(4);

    switches = 4'h3; enter = 1'b1;
    tick(50);
    wait_digit(8'hFE, 8'hB0, "one_d0");
    wait_digit(8'hFD, 8'hFF, "one_d1");

    enter = 1'b0;
    tick(5);
    switches = 4'h4; enter = 1'b1;
    tick(10);
    enter = 1'b0;
    wait_digit(8'hFE, 8'h99, "two_d0");
    wait_digit(8'hFD, 8'hB0, "two_d1");

    for (int v = 0; v < 9; v++) begin
      switches = 4'(v); enter = 1'b1;
      tick(6);
      enter = 1'b0;
      tick(6);
    end
    tick(4);
    wait_digit(8'h7F, 8'hF9, "full_d7");
    wait_digit(8'hFE, 8'h80, "full_d0");
    wait_digit(8'hBF, 8'hA4, "full_d6");

    // Reset pulse entirely between two clock edges.
    @(posedge clk);
    #5 reset = 1'b0;
    #1;
    check("async_anodes", anodes, 8'hFF);
    check("async_cathodes", cathodes, 8'hFF);
    #8 reset = 1'b1;
    tick(40);
    wait_digit(8'hFE, 8'hFF, "after_d0");
    wait_digit(8'h7F, 8'hFF, "after_d7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
